mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the uMIPS_32 execute stage. It owns the HI/LO registers.
- It is the controller end of the pipeline-register write-enable interface. It drives stall_n, which the pipeline ties to the e input of its enable registers. This freezes the pipeline when an mfhi/mflo reads while an operation is in flight.
- It implements mult, multu, div and divu by radix-2 shift-add and restoring division, plus mthi/mtlo.

Parameters:
- XLEN, 32, operand width; HI/LO each XLEN bits.
- ITERS, 32, iteration cycles per operation; must equal XLEN.

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  data for mthi/mtlo
- read_req  in  1  decode stage holds an mfhi/mflo
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight (registered)
- done  out  1  one-cycle pulse when HI/LO updated by an operation
- div0  out  1  last div/divu had b==0; sticky until next start
- stall_n  out  1  ~(busy & read_req), combinational; drives pipeline e

Behaviour:
- Reset: clock clk, reset clrn asynchronous active-low. With clrn low: state=IDLE, hi=0, lo=0, busy=0, done=0, div0=0, internal accumulators=0.
- Reset mid-operation aborts the operation. No partial result reaches HI/LO.
- FSM states are IDLE, MUL, DIV and FIX.
- IDLE -> MUL or DIV: start=1 at edge N latches the operand magnitudes.
  - Signed ops take the absolute value of a and b.
  - The unit also latches the result signs: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - The unit clears the iteration counter, sets busy=1 and clears div0.
- MUL:
  - One shift-add step per cycle on a 64-bit accumulator.
  - Counter 0..31; at count 31 go to FIX.
- DIV:
  - One restoring step per cycle: shift the {rem,quo} pair left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - Count 31 -> FIX.
- FIX:
  - Apply two's-complement sign correction for signed ops.
  - Write at edge N+33: hi = product[63:32] or remainder; lo = product[31:0] or quotient.
  - Set done=1 and busy=0 after edge N+33, then return to IDLE. done clears the next cycle.
- Latency: start at edge N -> busy high cycles N+1..N+33 -> done high in cycle N+34 (33 busy cycles).
- Divide by zero:
  - Runs the normal 33 cycles.
  - Result: lo=32'hFFFFFFFF, hi=original a (unsigned view); div0=1.
  - Signed div by zero uses the same values with no sign fix.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Magnitude arithmetic produces this without special casing.
- start while busy is ignored; the operation in flight is not disturbed.
- mthi/mtlo:
  - In IDLE with start=0, the register is written at the next edge.
  - mthi and mtlo together write both registers.
  - While busy, or in the same cycle as an accepted start, they are ignored (start has priority).
- stall_n:
  - Low in every cycle where busy=1 and read_req=1, including the FIX cycle.
  - High in the done cycle, so mfhi reads the updated HI then.
- hi/lo hold their value at all times except at the FIX write or an mthi/mtlo write.

Test Plan:
- Reset: drive clrn=0 during a MUL operation at iteration 10 -> hi=lo=0, busy=0, done=0 immediately; no later done.
- multu: a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge N -> busy for 33 cycles, done in N+34, hi=0xFFFFFFFE, lo=0x00000001.
- mult: a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div: a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div overflow and div-by-zero:
  - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
  - divu a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, div0=1.
- Stall and priority:
  - read_req=1 from cycle N+2 -> stall_n=0 through N+33, 1 in N+34.
  - start pulsed again at N+5 -> ignored.
  - mthi wdata=0xAA at N+10 -> ignored.
  - mtlo wdata=0x55 in IDLE -> lo=0x55 next edge.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the execute stage.
// Owns HI/LO. Multiplies by radix-2 shift-add and divides by restoring
// division, one step per cycle on operand magnitudes. A final FIX cycle
// applies the sign correction and writes HI/LO.
// stall_n freezes the pipeline while an mfhi/mflo waits on an operation
// that is still in flight.
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  input  logic            read_req,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div0,
  output logic            stall_n
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0] acc;
  // Multiplicand magnitude (mul) or divisor magnitude (div).
  logic [XLEN-1:0]   dvs;
  logic [XLEN-1:0]   a_raw;
  logic              is_div;
  logic              sgn_q;
  logic              sgn_r;
  logic              b_zero;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   hi_res;
  logic [XLEN-1:0]   lo_res;

  // Magnitude of an operand; only negated for signed operations.
  function automatic logic [XLEN-1:0] abs_x(input logic signed [XLEN-1:0] v,
                                            input logic sgn_op);
    logic signed [XLEN-1:0] r;
    r = (sgn_op && (v < 0)) ? -v : v;
    return r;
  endfunction

  // Two's-complement sign correction of a single-width result.
  function automatic logic [XLEN-1:0] sfix_x(input logic [XLEN-1:0] v,
                                             input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Two's-complement sign correction of the double-width product.
  function automatic logic [2*XLEN-1:0] sfix_2x(input logic [2*XLEN-1:0] v,
                                                input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign stall_n = ~(busy & read_req);

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: start is only honoured in IDLE; both loops run ITERS steps.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = op[1] ? DIV : MUL;
      MUL:  if (cnt == CW'(ITERS - 1)) state_nx = FIX;
      DIV:  if (cnt == CW'(ITERS - 1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One shift-add step and one restoring-division step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, dvs};
    if (div_diff[XLEN+1])
      div_next = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Final results; divide by zero bypasses the sign fix entirely.
  always_comb begin
    prod_fix = sfix_2x(acc, sgn_q);
    hi_res   = prod_fix[2*XLEN-1:XLEN];
    lo_res   = prod_fix[XLEN-1:0];
    if (is_div) begin
      if (b_zero) begin
        hi_res = a_raw;
        lo_res = '1;
      end else begin
        hi_res = sfix_x(acc[2*XLEN-1:XLEN], sgn_r);
        lo_res = sfix_x(acc[XLEN-1:0], sgn_q);
      end
    end
  end

  // Operand latch, iteration datapath, HI/LO and status flags.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt    <= '0;
      acc    <= '0;
      dvs    <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            a_raw  <= a;
            is_div <= op[1];
            sgn_q  <= ~op[0] & (a[XLEN-1] ^ b[XLEN-1]);
            sgn_r  <= ~op[0] & a[XLEN-1];
            b_zero <= (b == '0);
            busy   <= 1'b1;
            div0   <= 1'b0;
            if (op[1]) begin
              acc <= {{XLEN{1'b0}}, abs_x(a, ~op[0])};
              dvs <= abs_x(b, ~op[0]);
            end else begin
              acc <= {{XLEN{1'b0}}, abs_x(b, ~op[0])};
              dvs <= abs_x(a, ~op[0]);
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi   <= hi_res;
          lo   <= lo_res;
          done <= 1'b1;
          busy <= 1'b0;
          div0 <= is_div & b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: directed scenarios plus randomized operations
// compared against an arithmetic reference model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        read_req = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;
  logic        stall_n;

  int n_checks = 0;
  int n_pass   = 0;

  mdu_iter dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .read_req(read_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0),
    .stall_n(stall_n)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // MIPS HI/LO semantics from plain arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml, output logic md);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    md = 1'b0;
    mh = '0;
    ml = '0;
    if (o == 2'b00) begin
      p  = sx * sy;
      mh = p[63:32];
      ml = p[31:0];
    end else if (o == 2'b01) begin
      p  = {32'b0, x} * {32'b0, y};
      mh = p[63:32];
      ml = p[31:0];
    end else if (y == 32'd0) begin
      mh = x;
      ml = 32'hFFFF_FFFF;
      md = 1'b1;
    end else if (o == 2'b11) begin
      ml = x / y;
      mh = x % y;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      ml = q[31:0];
      mh = r[31:0];
    end
  endfunction

  // Runs one operation, checking latency, busy length and results.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    logic        ed;
    int          cyc, nbusy;
    model(o, x, y, eh, el, ed);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    chk1({tag, " div0_clr"}, div0, 1'b0);
    cyc = 1; nbusy = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk32({tag, " done_cyc"}, cyc, 32'd34);
    chk32({tag, " busy_len"}, nbusy, 32'd33);
    chk1({tag, " busy_off"}, busy, 1'b0);
    chk32({tag, " hi"}, hi, eh);
    chk32({tag, " lo"}, lo, el);
    chk1({tag, " div0"}, div0, ed);
    @(negedge clk);
    chk1({tag, " done_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb, hold_hi;
    logic [1:0]  ro;
    logic        ed;
    int          bad, seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk32("rst hi", hi, 32'd0);
    chk32("rst lo", lo, 32'd0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst div0", div0, 1'b0);
    chk1("rst stall_n", stall_n, 1'b1);
    clrn = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk32("multu_max hi_const", hi, 32'hFFFF_FFFE);
    chk32("multu_max lo_const", lo, 32'h0000_0001);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3);
    chk32("mult_neg lo_const", lo, 32'hFFFF_FFEB);
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk32("div_neg lo_const", lo, 32'hFFFF_FFFD);
    chk32("div_neg hi_const", hi, 32'hFFFF_FFFF);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk32("div_ovf lo_const", lo, 32'h8000_0000);
    do_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0);
    chk1("divu_zero div0_const", div0, 1'b1);
    do_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
    do_op("div_negneg", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    // Stall, ignored start and ignored mthi while busy
    model(2'b01, 32'h0001_0003, 32'h0002_0005, eh, el, ed);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h0001_0003; b = 32'h0002_0005;
    @(negedge clk);
    start = 1'b0;
    #1 chk1("stall idle_req", stall_n, 1'b1);
    bad = 0;
    for (int c = 2; c <= 33; c++) begin
      @(negedge clk);
      if (c == 2) read_req = 1'b1;
      if (c == 5) begin start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd7; end
      if (c == 6) start = 1'b0;
      if (c == 10) begin mthi = 1'b1; wdata = 32'h0000_00AA; end
      if (c == 11) mthi = 1'b0;
      #1;
      if (stall_n !== 1'b0) bad++;
    end
    chk32("stall low_cycles", bad, 32'd0);
    @(negedge clk);
    #1;
    chk1("stall done_cycle", stall_n, 1'b1);
    chk1("stall done", done, 1'b1);
    chk32("stall hi", hi, eh);
    chk32("stall lo", lo, el);
    read_req = 1'b0;
    @(negedge clk);
    chk1("ignored_start busy", busy, 1'b0);
    chk1("ignored_start done", done, 1'b0);

    // mtlo / mthi in IDLE
    hold_hi = hi;
    mtlo = 1'b1; wdata = 32'h0000_0055;
    @(negedge clk);
    mtlo = 1'b0;
    chk32("mtlo lo", lo, 32'h0000_0055);
    chk32("mtlo hi_keep", hi, hold_hi);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk32("mthilo hi", hi, 32'hCAFE_0001);
    chk32("mthilo lo", lo, 32'hCAFE_0001);

    // Start has priority over mthi in the same cycle
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7; mthi = 1'b1; wdata = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk32("prio hi_keep", hi, 32'hCAFE_0001);
    chk1("prio busy", busy, 1'b1);
    seen = 0;
    while (!done && seen < 40) begin @(negedge clk); seen++; end
    chk32("prio hi", hi, 32'd2);
    chk32("prio lo", lo, 32'd14);

    // Reset at iteration 10 of a multiply aborts without a late done
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h8765_4321;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    clrn = 1'b0;
    #1;
    chk32("abort hi", hi, 32'd0);
    chk32("abort lo", lo, 32'd0);
    chk1("abort busy", busy, 1'b0);
    chk1("abort done", done, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk32("abort no_done", seen, 32'd0);
    chk32("abort hi_after", hi, 32'd0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 5) rb = 32'd0;
      if (i % 6 == 4) rb = rb >> $urandom_range(0, 31);
      do_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
